// File: rtl/video_source_mux_pkg.sv
// Shared types and helpers for the video source selector: FSM encoding,
// select-width arithmetic and config tuple sizing.
package video_source_mux_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    // Config tuple {sel, ovl_en, ovl_sel}.
    function automatic int cfg_w(input int sel_w);
        return 2 * sel_w + 1;
    endfunction

endpackage

// File: rtl/video_source_mux_if.sv
// Pixel-source bundle between the generators/sync logic and the selector.
interface video_source_mux_if
    import video_source_mux_pkg::*;
#(
    parameter int N_SRC   = 5,
    parameter int COLOR_W = 4
) ();
    localparam int SEL_W = clog2(N_SRC);
    localparam int PIX_W = 3 * COLOR_W;

    logic [N_SRC*PIX_W-1:0] src_rgb;
    logic [SEL_W-1:0]       sel;
    logic                   ovl_en;
    logic [SEL_W-1:0]       ovl_sel;
    logic                   frame_start;
    logic                   de_in;
    logic [PIX_W-1:0]       rgb_out;
    logic                   de_out;
    logic [SEL_W-1:0]       cur_sel;
    logic                   switching;

    modport master (
        output src_rgb, sel, ovl_en, ovl_sel, frame_start, de_in,
        input  rgb_out, de_out, cur_sel, switching
    );

    modport slave (
        input  src_rgb, sel, ovl_en, ovl_sel, frame_start, de_in,
        output rgb_out, de_out, cur_sel, switching
    );
endinterface

// File: rtl/video_source_mux_cfg_commit_fsm.sv
// Holds the committed source/overlay config and applies requested changes
// only on frame boundaries, optionally blanking whole frames afterwards.
module video_source_mux_cfg_commit_fsm
    import video_source_mux_pkg::*;
#(
    parameter int CFG_W        = 7,
    parameter int BLANK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] req_cfg_i,
    input  logic             frame_start_i,
    output logic [CFG_W-1:0] cfg_o,
    output logic             switching_o,
    output logic             blank_o
);
    localparam int     CNT_W     = clog2(BLANK_FRAMES + 1);
    localparam logic   HAS_BLANK = (BLANK_FRAMES != 0);
    localparam state_e COMMIT_ST = HAS_BLANK ? ST_BLANK : ST_ACTIVE;

    state_e           state_q;
    logic [CFG_W-1:0] cfg_q, pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sw_q;
    logic             differs;

    assign differs = (req_cfg_i != cfg_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            cfg_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
        end else begin
            // Pending always tracks the live request; only a commit moves it.
            pend_q <= req_cfg_i;
            case (state_q)
                ST_ACTIVE: begin
                    if (differs && frame_start_i) begin
                        cfg_q   <= req_cfg_i;
                        cnt_q   <= CNT_W'(BLANK_FRAMES);
                        state_q <= COMMIT_ST;
                        sw_q    <= HAS_BLANK;
                    end else if (differs) begin
                        state_q <= ST_PENDING;
                        sw_q    <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!differs) begin
                        state_q <= ST_ACTIVE;
                        sw_q    <= 1'b0;
                    end else if (frame_start_i) begin
                        cfg_q   <= pend_q;
                        cnt_q   <= CNT_W'(BLANK_FRAMES);
                        state_q <= COMMIT_ST;
                        sw_q    <= HAS_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (frame_start_i) begin
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else if (differs) begin
                            cfg_q <= req_cfg_i;
                            cnt_q <= CNT_W'(BLANK_FRAMES);
                        end else begin
                            state_q <= ST_ACTIVE;
                            sw_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ACTIVE;
                    sw_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_o       = cfg_q;
    assign switching_o = sw_q;
    assign blank_o     = (state_q == ST_BLANK);
endmodule

// File: rtl/video_source_mux.sv
// Registered pixel-source selector with colour-key overlay; the mux only
// ever looks at the frame-aligned committed config.
module video_source_mux
    import video_source_mux_pkg::*;
#(
    parameter int                                 N_SRC         = 5,
    parameter int                                 COLOR_W       = 4,
    parameter int                                 BLANK_FRAMES  = 2,
    parameter logic [3*COLOR_W-1:0]               KEY_COLOR     = '0,
    parameter logic [3*COLOR_W-1:0]               DEFAULT_COLOR = '1
) (
    input  logic               clk,
    input  logic               rst,
    video_source_mux_if.slave  vif
);
    localparam int SEL_W = clog2(N_SRC);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int CFG_W = cfg_w(SEL_W);

    logic [N_SRC-1:0][PIX_W-1:0] src;
    logic [CFG_W-1:0]            cfg;
    logic [SEL_W-1:0]            c_sel, c_ovl_sel;
    logic                        c_ovl_en;
    logic                        blank, switching;
    logic                        base_ok, ovl_ok;
    logic [PIX_W-1:0]            base_pix, ovl_pix, pix_d, rgb_q;
    logic                        de_q;

    assign src = vif.src_rgb;

    video_source_mux_cfg_commit_fsm #(
        .CFG_W        (CFG_W),
        .BLANK_FRAMES (BLANK_FRAMES)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .req_cfg_i     ({vif.sel, vif.ovl_en, vif.ovl_sel}),
        .frame_start_i (vif.frame_start),
        .cfg_o         (cfg),
        .switching_o   (switching),
        .blank_o       (blank)
    );

    assign {c_sel, c_ovl_en, c_ovl_sel} = cfg;

    // Extra bit keeps the range compare legal when N_SRC is a power of two.
    assign base_ok  = ({1'b0, c_sel}     < (SEL_W+1)'(N_SRC));
    assign ovl_ok   = ({1'b0, c_ovl_sel} < (SEL_W+1)'(N_SRC));
    assign base_pix = base_ok ? src[c_sel] : DEFAULT_COLOR;
    assign ovl_pix  = ovl_ok ? src[c_ovl_sel] : KEY_COLOR;
    assign pix_d    = (c_ovl_en && ovl_ok && (ovl_pix != KEY_COLOR)) ? ovl_pix : base_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            de_q  <= vif.de_in;
            rgb_q <= (!vif.de_in || blank) ? '0 : pix_d;
        end
    end

    assign vif.rgb_out   = rgb_q;
    assign vif.de_out    = de_q;
    assign vif.cur_sel   = c_sel;
    assign vif.switching = switching;
endmodule

// File: tb/tb_video_source_mux.sv
// Directed bench for video_source_mux: reset, frame-aligned switching with
// blanking, cancelled requests, invalid index, overlay keying and DE timing.
module tb_video_source_mux;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    video_source_mux_if #(.N_SRC(5), .COLOR_W(4)) vif ();

    video_source_mux #(
        .N_SRC         (5),
        .COLOR_W       (4),
        .BLANK_FRAMES  (2),
        .KEY_COLOR     (12'h000),
        .DEFAULT_COLOR (12'hFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    logic [11:0] s0, s1, s2, s3, s4;

    task automatic load_src();
        vif.src_rgb = {s4, s3, s2, s1, s0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle frame_start pulse in the non-visible region.
    task automatic frame_pulse();
        vif.de_in       = 1'b0;
        vif.frame_start = 1'b1;
        tick();
        vif.frame_start = 1'b0;
        vif.de_in       = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        s0 = 12'h111; s1 = 12'h222; s2 = 12'h333; s3 = 12'h444; s4 = 12'h555;
        load_src();
        rst             = 1'b1;
        vif.sel         = '0;
        vif.ovl_en      = 1'b0;
        vif.ovl_sel     = '0;
        vif.frame_start = 1'b0;
        vif.de_in       = 1'b1;
        tick();
        tick();
        chk("rst_rgb", 32'(vif.rgb_out), 32'h0);
        chk("rst_de", 32'(vif.de_out), 32'h0);
        chk("rst_cur_sel", 32'(vif.cur_sel), 32'h0);
        chk("rst_switching", 32'(vif.switching), 32'h0);

        rst = 1'b0;
        tick();
        chk("post_rst_rgb", 32'(vif.rgb_out), 32'h111);
        chk("post_rst_de", 32'(vif.de_out), 32'h1);

        // Asynchronous reset in the middle of a visible line.
        rst = 1'b1;
        #1;
        chk("async_rst_rgb", 32'(vif.rgb_out), 32'h0);
        chk("async_rst_de", 32'(vif.de_out), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("resume_src0", 32'(vif.rgb_out), 32'h111);

        // Switch 0 -> 2 with two blank frames.
        vif.sel = 3'd2;
        tick();
        chk("sw_pending", 32'(vif.switching), 32'h1);
        chk("sw_old_pix", 32'(vif.rgb_out), 32'h111);
        tick();
        chk("sw_old_cur", 32'(vif.cur_sel), 32'h0);
        frame_pulse();
        chk("sw_commit_cur", 32'(vif.cur_sel), 32'h2);
        chk("sw_blank_sw", 32'(vif.switching), 32'h1);
        tick();
        chk("sw_blank1_pix", 32'(vif.rgb_out), 32'h0);
        tick();
        frame_pulse();
        tick();
        chk("sw_blank2_pix", 32'(vif.rgb_out), 32'h0);
        chk("sw_blank2_sw", 32'(vif.switching), 32'h1);
        frame_pulse();
        chk("sw_done_sw", 32'(vif.switching), 32'h0);
        tick();
        chk("sw_new_pix", 32'(vif.rgb_out), 32'h333);

        // Cancelled request: 2 -> 3 -> 2 before any frame boundary.
        vif.sel = 3'd3;
        tick();
        chk("cancel_sw_hi", 32'(vif.switching), 32'h1);
        vif.sel = 3'd2;
        tick();
        chk("cancel_sw_lo", 32'(vif.switching), 32'h0);
        frame_pulse();
        tick();
        chk("cancel_pix", 32'(vif.rgb_out), 32'h333);
        chk("cancel_cur", 32'(vif.cur_sel), 32'h2);
        chk("cancel_no_blank", 32'(vif.switching), 32'h0);

        // Out-of-range select shows the default colour.
        vif.sel = 3'd6;
        tick();
        frame_pulse();
        tick();
        chk("inv_blank_pix", 32'(vif.rgb_out), 32'h0);
        frame_pulse();
        frame_pulse();
        tick();
        chk("inv_pix", 32'(vif.rgb_out), 32'hFFF);
        chk("inv_cur", 32'(vif.cur_sel), 32'h6);

        // Overlay of source 1 over source 0 with key 000.
        s0 = 12'h00F; s1 = 12'h000;
        load_src();
        vif.sel     = 3'd0;
        vif.ovl_en  = 1'b1;
        vif.ovl_sel = 3'd1;
        tick();
        frame_pulse();
        frame_pulse();
        frame_pulse();
        tick();
        chk("ovl_key_pix", 32'(vif.rgb_out), 32'h00F);
        s1 = 12'h0F0;
        load_src();
        tick();
        chk("ovl_top_pix", 32'(vif.rgb_out), 32'h0F0);

        // Live sel change must not affect the picture before a commit.
        vif.sel = 3'd4;
        tick();
        chk("live_sel_ignored", 32'(vif.rgb_out), 32'h0F0);
        vif.sel = 3'd0;
        tick();

        // DE delay and masking.
        vif.de_in = 1'b0;
        tick();
        chk("de_lo_out", 32'(vif.de_out), 32'h0);
        chk("de_lo_pix", 32'(vif.rgb_out), 32'h0);
        vif.de_in = 1'b1;
        tick();
        chk("de_hi_out", 32'(vif.de_out), 32'h1);
        chk("de_hi_pix", 32'(vif.rgb_out), 32'h0F0);
        vif.de_in = 1'b0;
        tick();
        chk("de_fall_out", 32'(vif.de_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/video_source_mux.md
Name: video_source_mux

Overview:
- Parametrised, registered successor to the top-level pixel-source selector.
- Selects one of N_SRC RGB pixel sources for the VGA display path, optionally keyed over a base source (colour-key overlay).
- Commits any source/overlay change only at a frame boundary, so the picture never tears, and can blank for a set number of frames around a switch.
- Sits between the pixel generators (strip, ROM, UART/SRAM, GIF) and vga_display, clocked by the pixel clock.

Parameters:
- N_SRC, 5, number of pixel sources (>=2).
- COLOR_W, 4, bits per colour component; pixel = 3*COLOR_W, packed {r,g,b}.
- BLANK_FRAMES, 2, whole frames forced black after a committed switch; 0 = no blanking.
- KEY_COLOR, 0, 3*COLOR_W transparency key for overlay mode.
- DEFAULT_COLOR, all ones, pixel driven when the selected index >= N_SRC.
- SEL_W, derived as clog2(N_SRC), width of the select fields (localparam).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- src_rgb  in  N_SRC*3*COLOR_W  source pixels; source i at bits [i*3*COLOR_W +: 3*COLOR_W].
- sel  in  SEL_W  requested base source.
- ovl_en  in  1  requested overlay enable.
- ovl_sel  in  SEL_W  requested overlay (top) source.
- frame_start  in  1  one-cycle pulse at h_cnt=0, v_cnt=0.
- de_in  in  1  visible-area data enable.
- rgb_out  out  3*COLOR_W  registered output pixel.
- de_out  out  1  de_in delayed by one cycle.
- cur_sel  out  SEL_W  committed base source.
- switching  out  1  high while a change is pending or blanking.

Behaviour:
- Reset (async, while rst=1):
  - rgb_out=0, de_out=0, cur_sel=0, switching=0.
  - Committed config {ovl_en=0, ovl_sel=0, sel=0}; pending config cleared; blank counter=0; state ACTIVE.
- Config tuple = {sel, ovl_en, ovl_sel}; "differs" means the requested tuple != the committed tuple.
- FSM states: ACTIVE, PENDING, BLANK.
- ACTIVE:
  - Tuple differs, no frame_start: latch the request into pending; go to PENDING.
  - Tuple differs and frame_start in the same cycle: commit the request immediately (COMMIT).
- PENDING:
  - Pending follows the request every cycle.
  - Request equals committed before a frame_start: return to ACTIVE; no blanking.
  - frame_start: COMMIT.
- COMMIT action:
  - Committed tuple <= pending (or the direct request).
  - BLANK_FRAMES=0: go to ACTIVE.
  - Otherwise: load cnt=BLANK_FRAMES; go to BLANK.
- BLANK:
  - Each frame_start decrements cnt.
  - At frame_start with cnt=1:
    - Request differs from committed: COMMIT again (reload cnt).
    - Otherwise: go to ACTIVE.
  - Requests arriving during BLANK update pending only; they never shorten the blank.
- switching = (state != ACTIVE), registered in the same cycle as the state.
- Pixel path (one-cycle latency; the sync chain must delay h_sync/v_sync by one cycle to match):
  - de_in=0: rgb_out <= 0.
  - state BLANK: rgb_out <= 0.
  - Otherwise base = src[cur_sel], or DEFAULT_COLOR if cur_sel >= N_SRC.
  - Overlay committed enabled with ovl_sel < N_SRC and src[ovl_sel] != KEY_COLOR: rgb_out <= src[ovl_sel]; else rgb_out <= base.
  - Overlay committed enabled with ovl_sel >= N_SRC: overlay ignored (base shown).
- Output mux uses the committed config only, never the live sel.
- Output may change mid-frame only via source data, never via a selection change.
- Reset mid-frame: outputs are 0 immediately; after release, a frame resumes on source 0 with no blanking.

Decomposition:
- Shared package (vga_pkg):
  - clog2 function.
  - FSM state encoding (ACTIVE/PENDING/BLANK).
  - Default DEFAULT_COLOR/KEY_COLOR constants.
  - Config tuple struct-like packing helper widths.
- Sub-module cfg_commit_fsm: owns the FSM, pending/committed config and blank counter; outputs the committed config and switching.
- The pixel mux/key datapath stays in video_source_mux.

Test Plan:
- Reset: assert rst mid-line with de_in=1 -> rgb_out=0, de_out=0, cur_sel=0 asynchronously; after release, first visible pixel = src0.
- Switch with blanking (N_SRC=5, BLANK_FRAMES=2): sel 0->2 mid-frame -> src0 until frame_start; next 2 frames rgb_out=0 and switching=1; third frame = src2, switching=0.
- Cancelled request: sel 0->3->0 before frame_start -> switching pulses high then low, no blank frames, cur_sel stays 0.
- Invalid index: sel=6 committed -> rgb_out=12'hFFF wherever de_in=1.
- Overlay: ovl_en=1, ovl_sel=1, sel=0 committed; src0=12'h00F:
  - src1=12'h000 (key) -> 12'h00F.
  - src1=12'h0F0 -> 12'h0F0.
- Latency/DE: de_in toggles -> de_out follows exactly 1 cycle later; rgb_out=0 whenever the delayed de is 0.
